// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants, state encoding and sizing helper for fc_layer_sequencer
package fc_pkg;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam int          FP_SIGN_BIT = 31;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    MAC,
    DRAIN,
    EMIT
  } fc_state_t;

  // Counter/index width for a range of 'depth' values, never narrower than 1 bit.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// rtl/fc_layer_sequencer_if.sv - activation, weight ROM, PE and result signal bundle
interface fc_layer_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 8,
  parameter int N_OUT      = 10
);
  import fc_pkg::*;

  localparam int IDX_W = addr_bits(N_OUT);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  logic                  w_rd;
  logic [AW-1:0]         w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  logic                  pe_start;
  logic [DATA_WIDTH-1:0] pe_input;
  logic [DATA_WIDTH-1:0] pe_weight;
  logic [DATA_WIDTH-1:0] pe_result;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;

  logic                  busy;

  modport master (
    input  in_valid, in_data, w_data, pe_result, out_ready,
    output in_ready, w_rd, w_addr, pe_start, pe_input, pe_weight,
           out_valid, out_data, out_idx, out_last, busy
  );

  modport slave (
    output in_valid, in_data, w_data, pe_result, out_ready,
    input  in_ready, w_rd, w_addr, pe_start, pe_input, pe_weight,
           out_valid, out_data, out_idx, out_last, busy
  );

endinterface

// File: rtl/fc_input_buffer.sv
// rtl/fc_input_buffer.sv - activation vector store, one write port and one registered read port
module fc_input_buffer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [addr_bits(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       rd_en,
  input  logic [addr_bits(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data
);

  // Contents survive reset; every vector overwrites all entries before use.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - feeds activation/weight pairs to the FC PE per neuron; FC_RELU_EN clamps negative results
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int N_IN       = 16,
  parameter int N_OUT      = 10,
  parameter int PE_LAT     = 1,
  parameter int AW         = 8
) (
  input logic                  clk,
  input logic                  reset,
  fc_layer_sequencer_if.master bus
);

  localparam int IW = addr_bits(N_IN);
  localparam int NW = addr_bits(N_OUT);
  localparam int DW = addr_bits(PE_LAT + 1);

  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PE_LAT);

  fc_state_t state;
  fc_state_t state_next;

  logic [IW-1:0]         i_cnt;
  logic [NW-1:0]         n_cnt;
  logic [DW-1:0]         d_cnt;
  logic                  pair_valid;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] result_c;

  logic i_last;
  logic n_last;
  logic d_last;
  logic load_fire;
  logic emit_fire;
  logic mac_active;

  logic in_ready_c;
  logic w_rd_c;
  logic pe_start_c;
  logic out_valid_c;
  logic busy_c;

  assign i_last     = (i_cnt == I_LAST);
  assign n_last     = (n_cnt == N_LAST);
  assign d_last     = (d_cnt == D_LAST);
  assign mac_active = (state == MAC);
  assign load_fire  = (state == LOAD) && bus.in_valid;
  assign emit_fire  = (state == EMIT) && bus.out_ready;

  fc_input_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (N_IN)
  ) u_input_buffer (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_addr (i_cnt),
    .wr_data (bus.in_data),
    .rd_en   (mac_active),
    .rd_addr (i_cnt),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    w_rd_c      = 1'b0;
    pe_start_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b1;
    unique case (state)
      IDLE: begin
        busy_c     = 1'b0;
        state_next = LOAD;
      end
      LOAD: begin
        busy_c     = 1'b0;
        in_ready_c = 1'b1;
        if (bus.in_valid && i_last) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        pe_start_c = 1'b1;
        state_next = MAC;
      end
      MAC: begin
        w_rd_c = 1'b1;
        if (i_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (d_last) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = n_last ? LOAD : CLEAR;
        end
      end
      default: begin
        busy_c     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

`ifdef FC_RELU_EN
  // Any sign-set word (including -0.0 and negative NaN) clamps to +0.0.
  assign result_c = bus.pe_result[FP_SIGN_BIT] ? DATA_WIDTH'(FP_ZERO) : bus.pe_result;
`else
  assign result_c = bus.pe_result;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      i_cnt      <= '0;
      n_cnt      <= '0;
      d_cnt      <= '0;
      pair_valid <= 1'b0;
      out_data_q <= '0;
    end else begin
      // ROM data and the buffer read both land one cycle after the MAC issue.
      pair_valid <= mac_active;
      if (load_fire || mac_active) begin
        i_cnt <= i_last ? '0 : i_cnt + IW'(1);
      end
      if (state == DRAIN) begin
        d_cnt <= d_last ? '0 : d_cnt + DW'(1);
        if (d_last) begin
          out_data_q <= result_c;
        end
      end
      if (emit_fire) begin
        n_cnt <= n_last ? '0 : n_cnt + NW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.w_rd      = w_rd_c;
  assign bus.w_addr    = AW'(int'(n_cnt) * N_IN + int'(i_cnt));
  assign bus.pe_start  = pe_start_c;
  assign bus.pe_input  = pair_valid ? buf_rd_data : DATA_WIDTH'(FP_ZERO);
  assign bus.pe_weight = pair_valid ? bus.w_data  : DATA_WIDTH'(FP_ZERO);
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = n_cnt;
  assign bus.out_last  = out_valid_c && n_last;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - randomized self-checking bench with behavioural ROM, PE and dot-product model
module tb_fc_layer_sequencer;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 2;
  localparam int PE_LAT = 1;
  localparam int AW     = 8;

  logic clk = 1'b0;
  logic reset;

  fc_layer_sequencer_if #(.DATA_WIDTH(32), .AW(AW), .N_OUT(N_OUT)) bus ();

  fc_layer_sequencer #(
    .DATA_WIDTH (32),
    .N_IN       (N_IN),
    .N_OUT      (N_OUT),
    .PE_LAT     (PE_LAT),
    .AW         (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int busy_bad = 0;
  bit keep_ready = 0;
  logic [31:0] rom [256];
  logic [AW-1:0] addr_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Normal single-precision values only; zero maps to +0.0.
  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) return 0.0;
    d = {b[31], 11'(int'(b[30:23]) + 896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_sp();
    int k;
    k = int'($urandom_range(16)) - 8;
    return r2sp(real'(k) * 0.5);
  endfunction

  function automatic logic [31:0] ref_neuron(input logic [31:0] v [N_IN], input int n);
    real s;
    logic [31:0] r;
    s = 0.0;
    for (int k = 0; k < N_IN; k++) s = s + sp2r(v[k]) * sp2r(rom[n * N_IN + k]);
    r = r2sp(s);
`ifdef FC_RELU_EN
    if (r[31]) r = 32'h0;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.w_rd) bus.w_data <= rom[bus.w_addr];
  end

  real acc = 0.0;
  always @(posedge clk) begin
    if (reset || bus.pe_start) acc = 0.0;
    else acc = acc + sp2r(bus.pe_input) * sp2r(bus.pe_weight);
    bus.pe_result <= r2sp(acc);
  end

  always @(negedge clk) begin
    if (bus.w_rd) addr_q.push_back(bus.w_addr);
    if (bus.in_ready && bus.busy) busy_bad++;
    if ((bus.w_rd || bus.pe_start || bus.out_valid) && !bus.busy) busy_bad++;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_ctrl"}, {bus.in_ready, bus.w_rd, bus.pe_start, bus.out_valid, bus.out_last, bus.busy}, 0);
    chk({tag, "_idx"}, bus.out_idx, 0);
    chk({tag, "_addr"}, bus.w_addr, 0);
    chk({tag, "_pe"}, {bus.pe_input, bus.pe_weight}, 0);
    chk({tag, "_out"}, bus.out_data, 0);
  endtask

  task automatic load_vec(input logic [31:0] v [N_IN], input bit toggle);
    int k = 0;
    int guard = 0;
    while (k < N_IN && guard < 200) begin
      @(negedge clk);
      guard++;
      bus.in_valid = toggle ? !bus.in_valid : 1'b1;
      bus.in_data  = bus.in_valid ? v[k] : $urandom;
      if (bus.in_valid && bus.in_ready) k++;
    end
    chk("load_timeout", guard < 200, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("clear_after_load", bus.pe_start, 1);
  endtask

  task automatic get_result(input logic [31:0] v [N_IN], input int n, input int stall,
                            input bit garbage, output logic [31:0] got);
    int guard = 0;
    int gbad = 0;
    int sbad = 0;
    logic [31:0] exp;
    exp = ref_neuron(v, n);
    @(negedge clk);
    while (!bus.out_valid && guard < 500) begin
      if (garbage) begin
        if (bus.in_ready) gbad++;
        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
      end
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("out_timeout", guard < 500, 1);
    if (garbage) chk("in_ready_outside_load", gbad, 0);
    chk("out_data", bus.out_data, exp);
    chk("out_idx", bus.out_idx, n);
    chk("out_last", bus.out_last, n == N_OUT - 1);
    got = bus.out_data;
    if (stall > 0) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        if (!bus.out_valid || bus.out_data !== exp || bus.out_idx != n || bus.pe_start || bus.w_rd) sbad++;
      end
      chk("stall_hold", sbad, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    if (!keep_ready) bus.out_ready = 1'b0;
    if (n < N_OUT - 1) chk("next_clear", bus.pe_start, 1);
    else chk("next_load", bus.in_ready, 1);
  endtask

  logic [31:0] vec [N_IN];
  logic [31:0] got;
  logic [31:0] exp2;
  int guard;
  int abad;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    reset = 1'b0;

    // Directed vector with a long EMIT stall on neuron 0.
    rom[0] = 32'h3F800000; rom[1] = 32'h3F800000; rom[2] = 32'h40000000; rom[3] = 32'h3F800000;
    for (int a = 4; a < 8; a++) rom[a] = 32'hBF800000;
    vec = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    load_vec(vec, 0);
    get_result(vec, 0, 20, 0, got);
    chk("t1_const", got, 32'h40A00000);
    get_result(vec, 1, 0, 0, got);
`ifdef FC_RELU_EN
    exp2 = 32'h00000000;
`else
    exp2 = 32'hC0900000;
`endif
    chk("t2_const", got, exp2);

    // Gapped in_valid during LOAD, junk in_valid while computing.
    for (int k = 0; k < N_IN; k++) vec[k] = rand_sp();
    load_vec(vec, 1);
    get_result(vec, 0, 0, 1, got);
    get_result(vec, 1, 0, 1, got);

    // Reset in the middle of neuron 1 MAC.
    for (int k = 0; k < N_IN; k++) vec[k] = rand_sp();
    load_vec(vec, 0);
    get_result(vec, 0, 0, 0, got);
    guard = 0;
    while (!(bus.w_rd && bus.w_addr == AW'(N_IN + 1)) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_mac_n1", guard < 200, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset("midrst");
    reset = 1'b0;
    for (int k = 0; k < N_IN; k++) vec[k] = rand_sp();
    load_vec(vec, 0);
    get_result(vec, 0, 0, 0, got);
    get_result(vec, 1, 0, 0, got);

    // Back-to-back vectors with out_ready held high.
    keep_ready = 1'b1;
    bus.out_ready = 1'b1;
    addr_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N_IN; k++) vec[k] = rand_sp();
      load_vec(vec, 0);
      get_result(vec, 0, 0, 0, got);
      get_result(vec, 1, 0, 0, got);
    end
    keep_ready = 1'b0;
    bus.out_ready = 1'b0;
    chk("addr_count", addr_q.size(), 2 * N_IN * N_OUT);
    abad = 0;
    foreach (addr_q[j]) if (addr_q[j] != AW'(j % (N_IN * N_OUT))) abad++;
    chk("addr_sequence", abad, 0);

    // Random weights, vectors, stalls and LOAD gaps.
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < N_IN * N_OUT; a++) rom[a] = rand_sp();
      for (int k = 0; k < N_IN; k++) vec[k] = rand_sp();
      load_vec(vec, 1'($urandom_range(1)));
      for (int n = 0; n < N_OUT; n++) begin
        get_result(vec, n, int'($urandom_range(3)), 1'($urandom_range(1)), got);
      end
    end

    chk("busy_rule", busy_bad, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
